// File: rtl/decode_hazard_controller_pkg.sv
// Shared types for the decode hazard controller: register index, FSM state
// and PC-mux redirect source.
package decode_hazard_controller_pkg;

  typedef logic [4:0] register_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hazard_state_e;

  typedef enum logic {
    REDIRECT_DECODE  = 1'b0,
    REDIRECT_EXECUTE = 1'b1
  } redirect_select_e;

endpackage

// File: rtl/decode_hazard_controller_scoreboard.sv
// In-flight write scoreboard: one saturating up/down counter per register
// (x0 untracked), two source lookups with retire bypass and a full flag for rd.
module decode_hazard_controller_scoreboard
  import decode_hazard_controller_pkg::*;
#(
  parameter int MAX_IN_FLIGHT = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_write,
  input  register_t issue_rd,
  input  logic      retire_valid,
  input  register_t retire_rd,
  input  register_t rs1_addr,
  input  register_t rs2_addr,
  input  register_t rd_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rd_full
);

  localparam int CW = $clog2(MAX_IN_FLIGHT + 1);

  logic [CW-1:0] pending [32];
  logic [31:0]   inc_mask;
  logic [31:0]   dec_mask;
  logic          rs1_retiring;
  logic          rs2_retiring;

  always_comb begin
    inc_mask = '0;
    dec_mask = '0;
    if (issue_write && issue_rd != '0) inc_mask[issue_rd] = 1'b1;
    if (retire_valid && retire_rd != '0) dec_mask[retire_rd] = 1'b1;
  end

  // A retire in the same cycle lands in the register file first, so it
  // already counts against the lookup.
  assign rs1_retiring = retire_valid && (retire_rd == rs1_addr);
  assign rs2_retiring = retire_valid && (retire_rd == rs2_addr);
  assign rs1_busy = (rs1_addr != '0) && (pending[rs1_addr] > CW'(rs1_retiring));
  assign rs2_busy = (rs2_addr != '0) && (pending[rs2_addr] > CW'(rs2_retiring));
  assign rd_full  = (rd_addr != '0) && (pending[rd_addr] == CW'(MAX_IN_FLIGHT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) pending[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_mask[r] && !dec_mask[r])
          pending[r] <= pending[r] + CW'(1);
        else if (dec_mask[r] && !inc_mask[r] && pending[r] != '0)
          pending[r] <= pending[r] - CW'(1);
      end
    end
  end

  retire_underflow: assert property (@(posedge clk) disable iff (rst)
    (retire_valid && retire_rd != '0) |-> (pending[retire_rd] != '0));

endmodule

// File: rtl/decode_hazard_controller.sv
// Decode-stage sequencer: RAW/scoreboard hold, issue, early and late
// redirects with a flush window, and a stall-cycle counter.
module decode_hazard_controller
  import decode_hazard_controller_pkg::*;
#(
  parameter int MAX_IN_FLIGHT    = 4,
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        decode_valid_i,
  input  register_t   rs1_address_i,
  input  logic        rs1_used_i,
  input  register_t   rs2_address_i,
  input  logic        rs2_used_i,
  input  register_t   rd_address_i,
  input  logic        write_enable_i,
  input  logic        jump_target_valid_i,
  input  logic        execute_ready_i,
  input  logic        redirect_i,
  input  logic        retire_valid_i,
  input  register_t   retire_rd_i,
  output logic        issue_o,
  output logic        fetch_stall_o,
  output logic        decode_flush_o,
  output logic        fetch_redirect_o,
  output logic        redirect_select_o,
  output logic        hazard_o,
  output logic [31:0] stall_count_o
);

  localparam int BW = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;

  hazard_state_e    state;
  logic [BW-1:0]    bubble_count;
  redirect_select_e sel;
  logic rs1_busy, rs2_busy, rd_full;
  logic hazard, run, issue, early_jump, stall;

  decode_hazard_controller_scoreboard #(.MAX_IN_FLIGHT(MAX_IN_FLIGHT)) u_scoreboard (
    .clk          (clk_i),
    .rst          (rst_i),
    .issue_write  (issue && write_enable_i),
    .issue_rd     (rd_address_i),
    .retire_valid (retire_valid_i),
    .retire_rd    (retire_rd_i),
    .rs1_addr     (rs1_address_i),
    .rs2_addr     (rs2_address_i),
    .rd_addr      (rd_address_i),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .rd_full      (rd_full)
  );

  assign hazard = decode_valid_i && ((rs1_used_i && rs1_busy) ||
                                     (rs2_used_i && rs2_busy) ||
                                     (write_enable_i && rd_full));

  assign run        = (state == RUN);
  assign issue      = run && decode_valid_i && !hazard && execute_ready_i && !redirect_i;
  assign early_jump = issue && jump_target_valid_i;
  assign stall      = run && decode_valid_i && !issue && !redirect_i;
  assign sel        = redirect_i ? REDIRECT_EXECUTE : REDIRECT_DECODE;

  // Everything is forced low during reset, including the combinational paths.
  assign issue_o           = !rst_i && issue;
  assign fetch_stall_o     = !rst_i && stall;
  assign decode_flush_o    = !rst_i && (redirect_i || !run);
  assign fetch_redirect_o  = !rst_i && (redirect_i || early_jump);
  assign redirect_select_o = !rst_i && (sel == REDIRECT_EXECUTE);
  assign hazard_o          = !rst_i && hazard;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      bubble_count  <= '0;
      stall_count_o <= '0;
    end else begin
      if (stall) stall_count_o <= stall_count_o + 32'd1;
      if (redirect_i || early_jump) begin
        state        <= FLUSH;
        bubble_count <= BW'(REDIRECT_BUBBLES - 1);
      end else if (state == FLUSH) begin
        if (bubble_count == '0) state <= RUN;
        else bubble_count <= bubble_count - BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Self-checking bench for decode_hazard_controller: a table of per-cycle
// vectors plus hand-written reset sequences, checked through an expectation queue.
module tb_decode_hazard_controller;
  import decode_hazard_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        decode_valid_i = 1'b0;
  register_t   rs1_address_i = '0;
  logic        rs1_used_i = 1'b0;
  register_t   rs2_address_i = '0;
  logic        rs2_used_i = 1'b0;
  register_t   rd_address_i = '0;
  logic        write_enable_i = 1'b0;
  logic        jump_target_valid_i = 1'b0;
  logic        execute_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic        retire_valid_i = 1'b0;
  register_t   retire_rd_i = '0;
  logic        issue_o, fetch_stall_o, decode_flush_o, fetch_redirect_o;
  logic        redirect_select_o, hazard_o;
  logic [31:0] stall_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_hazard_controller #(.MAX_IN_FLIGHT(4), .REDIRECT_BUBBLES(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .decode_valid_i(decode_valid_i),
    .rs1_address_i(rs1_address_i), .rs1_used_i(rs1_used_i),
    .rs2_address_i(rs2_address_i), .rs2_used_i(rs2_used_i),
    .rd_address_i(rd_address_i), .write_enable_i(write_enable_i),
    .jump_target_valid_i(jump_target_valid_i), .execute_ready_i(execute_ready_i),
    .redirect_i(redirect_i), .retire_valid_i(retire_valid_i), .retire_rd_i(retire_rd_i),
    .issue_o(issue_o), .fetch_stall_o(fetch_stall_o), .decode_flush_o(decode_flush_o),
    .fetch_redirect_o(fetch_redirect_o), .redirect_select_o(redirect_select_o),
    .hazard_o(hazard_o), .stall_count_o(stall_count_o)
  );

  // exp = {issue, fetch_stall, decode_flush, fetch_redirect, redirect_select, hazard}
  typedef struct {
    logic dv; register_t rs1; logic u1; register_t rs2; logic u2;
    register_t rd; logic we; logic jmp; logic rdy; logic redir;
    logic rv; register_t rr; logic [5:0] exp;
  } vec_t;

  typedef struct { string name; logic [5:0] exp; } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(logic dv, register_t rs1, logic u1, register_t rs2, logic u2,
                              register_t rd, logic we, logic jmp, logic rdy, logic redir,
                              logic rv, register_t rr, logic [5:0] exp);
    vec_t v;
    v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.we = we;
    v.jmp = jmp; v.rdy = rdy; v.redir = redir; v.rv = rv; v.rr = rr; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    decode_valid_i = v.dv; rs1_address_i = v.rs1; rs1_used_i = v.u1;
    rs2_address_i = v.rs2; rs2_used_i = v.u2; rd_address_i = v.rd;
    write_enable_i = v.we; jump_target_valid_i = v.jmp; execute_ready_i = v.rdy;
    redirect_i = v.redir; retire_valid_i = v.rv; retire_rd_i = v.rr;
  endtask

  task automatic check_outputs();
    exp_t e;
    logic [5:0] got;
    e = exp_q.pop_front();
    got = {issue_o, fetch_stall_o, decode_flush_o, fetch_redirect_o, redirect_select_o, hazard_o};
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", e.name, got, e.exp);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.name = name; e.exp = v.exp;
    exp_q.push_back(e);
    #1;
    check_outputs();
  endtask

  task automatic check_count(input string name, input logic [31:0] exp);
    checks++;
    if (stall_count_o !== exp) begin
      errors++;
      $display("FAIL %s: stall_count_o got %0d expected %0d", name, stall_count_o, exp);
    end
  endtask

  initial begin
    exp_t e;

    // Reset: aggressive inputs must not leak through while rst_i is high.
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 4, 1, 1, 1, 1, 0, 0, 6'b000000));
    e.name = "reset_outputs"; e.exp = 6'b000000; exp_q.push_back(e);
    #1;
    check_outputs();
    check_count("reset_count", 32'd0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    @(negedge clk);
    rst_i = 1'b0;

    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000)); // idle
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 6'b100000)); // issue write x5
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b010001)); // RAW on x5
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b010001));
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, 5, 6'b100000)); // retire bypass
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b100000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 6'b100000)); // write x0
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 6'b100000)); // read x0
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 6'b100000)); // write x9
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 0, 6'b010001)); // rs2 RAW
    vecs.push_back(mk(1, 9, 0, 9, 0, 0, 0, 0, 1, 0, 0, 0, 6'b100000)); // unused sources
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 6'b000000)); // retire x9
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 6'b100100)); // early jump
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001000)); // flush bubble
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b100000)); // back in RUN
    vecs.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 1, 0, 0, 6'b001110)); // late beats early
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b001110)); // redirect in FLUSH
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001000)); // restarted bubble
    vecs.push_back(mk(1, 12, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b100000)); // x12 never counted
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b010000)); // execute busy
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 6'b100000)); // fill x7
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 6'b010001)); // x7 full
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 1, 7, 6'b010001)); // full ignores retire, ->3
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 1, 7, 6'b100000)); // issue+retire, stays 3
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 6'b100000)); // ->4
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 6'b010001)); // full again
    vecs.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 1, 7, 6'b010001)); // eff 3, ->3
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 6'b000000)); // drain x7
    vecs.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b100000)); // x7 clear

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);
    check_count("stall_total", 32'd8);

    // Reset in the middle of FLUSH discards state and pending writes.
    apply("seq_write_x3", mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 6'b100000));
    apply("seq_redirect", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001110));
    @(negedge clk);
    drive(mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000000));
    rst_i = 1'b1;
    e.name = "midflush_reset"; e.exp = 6'b000000; exp_q.push_back(e);
    #1;
    check_outputs();
    check_count("midflush_count", 32'd0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    @(negedge clk);
    rst_i = 1'b0;
    apply("post_reset_run", mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b100000));
    apply("post_reset_stall", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b010000));
    @(negedge clk);
    check_count("post_reset_count", 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
